// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder controller: one decimal digit per clock through a shared digit slice.
// Optional BCD_SUB_EN macro adds a sub port (nine's-complement subtraction).
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err,
  output logic [1:0]          state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [W-1:0]     a_q, b_q;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             sub_q;

  logic [3:0] a_dig [DIGITS];
  logic [3:0] b_dig [DIGITS];
  logic       bad;
  logic       last;
  logic       accept;
  logic       sub_in;
  logic [3:0] a_cur, b_cur, b_eff, digit;
  logic [4:0] t;
  logic       carry_nx;

`ifdef BCD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_split
    assign a_dig[g] = a_q[4*g +: 4];
    assign b_dig[g] = b_q[4*g +: 4];
  end

  // The digit check runs on the captured operands, in the first RUN cycle.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_dig[i] > 4'd9 || b_dig[i] > 4'd9) bad = 1'b1;
    end
  end

  assign accept    = in_valid && in_ready;
  assign last      = (idx == IDX_W'(DIGITS - 1));
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign state_dbg = state;

  // Shared digit slice with decimal correction.
  always_comb begin
    a_cur    = a_dig[idx];
    b_cur    = b_dig[idx];
    b_eff    = sub_q ? (4'd9 - b_cur) : b_cur;
    t        = {1'b0, a_cur} + {1'b0, b_eff} + {4'b0000, carry};
    digit    = t[3:0];
    carry_nx = 1'b0;
    if (t > 5'd9) begin
      digit    = t[3:0] + 4'd6;
      carry_nx = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_RUN;
      S_RUN:  if (bad || last) state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub_in;
            carry <= sub_in ? 1'b1 : cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
          end
        end
        S_RUN: begin
          if (bad) begin
            err  <= 1'b1;
            sum  <= '0;
            cout <= 1'b0;
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (idx == IDX_W'(i)) sum[4*i +: 4] <= digit;
            end
            carry <= carry_nx;
            if (last) cout <= carry_nx;
            else      idx  <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (DIGITS=4); BCD_SUB_EN vectors run when that macro is defined.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;
  logic [1:0]   state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef BCD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '1; b = '1; cin = 1'b0; sub = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_after_consume_in_ready", 32'(in_ready), 32'd1);
    check("idle_after_consume_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input logic [W-1:0] es,
                        input logic ec, input logic ee, input int elat);
    start_op(av, bv, cv, sv);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_err"}, 32'(err), 32'(ee));
    check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    consume();
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_45_37",   16'h0045, 16'h0037, 1'b0, 1'b0, 16'h0082, 1'b0, 1'b0, DIGITS);
    run_op("add_9999_1",  16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, DIGITS);
    run_op("add_1234_cin",16'h1234, 16'h5678, 1'b1, 1'b0, 16'h6913, 1'b0, 1'b0, DIGITS);
    run_op("err_a",       16'h00A1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
    run_op("err_b_top",   16'h0000, 16'hF000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
    run_op("add_5000",    16'h5000, 16'h5000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, DIGITS);
    run_op("add_9999_9999c", 16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, DIGITS);

    // Backpressure: result holds, new in_valid ignored
    start_op(16'h0045, 16'h0037, 1'b0, 1'b0);
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'(DIGITS));
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(sum), 32'h0082);
      check("bp_cout", 32'(cout), 32'd0);
    end
    in_valid = 1'b0;
    consume();
    check("bp_sum_after", 32'(sum), 32'h0082);

    // Asynchronous reset mid-RUN at idx=2
    start_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_state_run", 32'(state_dbg), 32'd1);
    check("pre_rst_partial_sum", 32'(sum), 32'h0012);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'h0808, 16'h0303, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b0, DIGITS);

`ifdef BCD_SUB_EN
    run_op("sub_100_1", 16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0, DIGITS);
    run_op("sub_1_2",   16'h0001, 16'h0002, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, DIGITS);
    run_op("sub_err_b", 16'h0001, 16'h000B, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
